// File: rtl/uart_packet_tx.sv
// uart_packet_tx: serializes 32-bit response packets MSB-first into a UART
// transmitter. Host XON/XOFF pauses data bytes at byte boundaries, and
// single control bytes requested by the receive side go out first.
//
// Handshakes:
//   pkt_valid/pkt_ready : a packet transfers on a clock edge where both are 1.
//                         pkt_ready is 1 exactly when the holding register is
//                         empty; pkt_data is ignored while a word is held.
//   fc_req/fc_ack       : fc_req is held with fc_byte stable until fc_ack
//                         pulses for one cycle, in the same cycle as the strobe
//                         that carries fc_byte.
//   tx_wr_n/tx_busy_n   : a write is tx_wr_n=0 for one cycle with tx_data
//                         valid. tx_busy_n is only looked at in ARB; during
//                         the guard window after a strobe it is ignored.
module uart_packet_tx #(
  parameter int unsigned GUARD_CYCLES = 2,
  parameter logic [7:0]  XOFF         = 8'h13,
  parameter logic [7:0]  XON          = 8'h11,
  parameter bit          FLOW_CTRL_EN = 1'b1
) (
  input  logic        clk100,
  input  logic        rst_n,
  input  logic [31:0] pkt_data,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic        fc_req,
  input  logic [7:0]  fc_byte,
  output logic        fc_ack,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_valid,
  output logic [7:0]  tx_data,
  output logic        tx_wr_n,
  input  logic        tx_busy_n,
  output logic        xoff_active,
  output logic [15:0] pkt_count,
  output logic        dbg_state
);

  typedef enum logic {
    ARB   = 1'b0,
    GUARD = 1'b1
  } state_t;

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  guard_cnt;
  logic [31:0] hold_word;
  logic        hold_valid;
  logic [1:0]  byte_idx;
  logic [7:0]  sel_byte;
  logic        do_fc;
  logic        do_data;
  logic        pkt_take;

  assign pkt_ready = !hold_valid;
  assign pkt_take  = pkt_valid && !hold_valid;
  assign dbg_state = state;

  // FSM state register
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration: control byte beats data; data waits for XON; nothing while busy
  always_comb begin
    state_next = state;
    do_fc      = 1'b0;
    do_data    = 1'b0;
    case (state)
      ARB: begin
        if (tx_busy_n) begin
          if (fc_req) begin
            do_fc      = 1'b1;
            state_next = GUARD;
          end else if (hold_valid && !xoff_active) begin
            do_data    = 1'b1;
            state_next = GUARD;
          end
        end
      end
      GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // Guard window counter, restarts on every entry into GUARD
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      guard_cnt <= 4'd0;
    end else if (state == GUARD && guard_cnt != GUARD_LAST) begin
      guard_cnt <= guard_cnt + 4'd1;
    end else begin
      guard_cnt <= 4'd0;
    end
  end

  // Byte select, MSB first
  always_comb begin
    sel_byte = hold_word[31:24];
    case (byte_idx)
      2'd0: sel_byte = hold_word[31:24];
      2'd1: sel_byte = hold_word[23:16];
      2'd2: sel_byte = hold_word[15:8];
      2'd3: sel_byte = hold_word[7:0];
      default: sel_byte = hold_word[31:24];
    endcase
  end

  // Holding register and byte position; the word is frozen while held
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      hold_word  <= 32'h0;
      hold_valid <= 1'b0;
      byte_idx   <= 2'd0;
    end else if (pkt_take) begin
      hold_word  <= pkt_data;
      hold_valid <= 1'b1;
      byte_idx   <= 2'd0;
    end else if (do_data) begin
      if (byte_idx == 2'd3) begin
        hold_valid <= 1'b0;
        byte_idx   <= 2'd0;
      end else begin
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

  // Completed packet counter, wraps naturally at 16 bits
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= 16'h0;
    end else if (do_data && byte_idx == 2'd3) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

  // Registered UART write port and control-byte acknowledge
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_n <= 1'b1;
      tx_data <= 8'h00;
      fc_ack  <= 1'b0;
    end else begin
      tx_wr_n <= !(do_fc || do_data);
      fc_ack  <= do_fc;
      if (do_fc) begin
        tx_data <= fc_byte;
      end else if (do_data) begin
        tx_data <= sel_byte;
      end
    end
  end

  // Host XON/XOFF decode; a pause only blocks the next ARB decision
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      xoff_active <= 1'b0;
    end else if (FLOW_CTRL_EN && rx_byte_valid) begin
      if (rx_byte == XOFF) begin
        xoff_active <= 1'b1;
      end else if (rx_byte == XON) begin
        xoff_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: packet table, XON/XOFF table, and hand-written
// sequences for busy stalls, pauses, control-byte insertion, wrap and reset.
module tb_uart_packet_tx;

  localparam int GUARD = 2;

  logic        clk100 = 1'b0;
  logic        rst_n;
  logic [31:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        fc_req;
  logic [7:0]  fc_byte;
  logic        fc_ack;
  logic [7:0]  rx_byte;
  logic        rx_byte_valid;
  logic [7:0]  tx_data;
  logic        tx_wr_n;
  logic        tx_busy_n;
  logic        xoff_active;
  logic [15:0] pkt_count;
  logic        dbg_state;

  // {is_control_byte, byte}
  logic [8:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  int cyc = 0;
  int last_cyc = -1;
  int exp_pkts = 0;

  typedef struct {
    logic [31:0]     data;
    logic [3:0][7:0] exp_b;
  } pkt_vec_t;

  typedef struct {
    logic [7:0] b;
    logic       v;
    logic       exp_xoff;
  } rx_vec_t;

  uart_packet_tx #(.GUARD_CYCLES(GUARD)) dut (
    .clk100(clk100), .rst_n(rst_n),
    .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .fc_req(fc_req), .fc_byte(fc_byte), .fc_ack(fc_ack),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .tx_data(tx_data), .tx_wr_n(tx_wr_n), .tx_busy_n(tx_busy_n),
    .xoff_active(xoff_active), .pkt_count(pkt_count), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk100 = ~clk100;

  // Watchdog
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move to just after the next falling edge (monitor samples on the edge)
  task automatic step();
    @(negedge clk100);
    #1;
  endtask

  task automatic push_byte(input logic is_fc, input logic [7:0] b);
    exp_q.push_back({is_fc, b});
  endtask

  task automatic send_pkt(input logic [31:0] d, input logic [3:0][7:0] exp_b, input bit push);
    int n;
    if (push) begin
      for (int i = 3; i >= 0; i--) push_byte(1'b0, exp_b[i]);
      exp_pkts++;
    end
    pkt_data  = d;
    pkt_valid = 1'b1;
    n = 0;
    while (!pkt_ready && n < 500) begin
      step();
      n++;
    end
    chk("pkt_accept_wait", 32'(pkt_ready), 32'd1);
    step();
    pkt_valid = 1'b0;
    pkt_data  = $urandom;
  endtask

  task automatic send_fc(input logic [7:0] b);
    int n;
    logic got;
    push_byte(1'b1, b);
    fc_byte = b;
    fc_req  = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 500) begin
      step();
      got = fc_ack;
      n++;
    end
    chk("fc_ack_seen", 32'(got), 32'd1);
    fc_req  = 1'b0;
    fc_byte = 8'($urandom_range(0, 255));
    step();
    chk("fc_ack_one_cycle", 32'(fc_ack), 32'd0);
  endtask

  task automatic rx_send(input logic [7:0] b);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    step();
    rx_byte_valid = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobe_cnt < target && n < budget) begin
      step();
      n++;
    end
    chk("wait_strobes", 32'(strobe_cnt), 32'(target));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      step();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    repeat (GUARD + 2) step();
  endtask

  // Scoreboard monitor: runs inside the main process via fork
  task automatic monitor();
    logic [8:0] e;
    forever begin
      @(negedge clk100);
      cyc++;
      if (rst_n !== 1'b1) begin
        last_cyc = -1;
      end else if (tx_wr_n === 1'b0) begin
        strobe_cnt++;
        chk("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e[7:0]));
          chk("fc_ack_with_strobe", 32'(fc_ack), 32'(e[8]));
        end
        if (last_cyc >= 0) chk("strobe_spacing", 32'(cyc - last_cyc >= GUARD + 1), 32'd1);
        last_cyc = cyc;
      end else if (fc_ack === 1'b1) begin
        chk("fc_ack_without_strobe", 32'(fc_ack), 32'd0);
      end
    end
  endtask

  pkt_vec_t pkt_tab[4];
  rx_vec_t  rx_tab[8];

  initial begin
    int sc;
    logic [3:0][7:0] bb;

    pkt_tab[0] = '{32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
    pkt_tab[1] = '{32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}};
    pkt_tab[2] = '{32'hFFFFFFFF, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    pkt_tab[3] = '{32'h80C0E0F1, {8'h80, 8'hC0, 8'hE0, 8'hF1}};

    rx_tab[0] = '{8'h13, 1'b1, 1'b1};
    rx_tab[1] = '{8'h55, 1'b1, 1'b1};
    rx_tab[2] = '{8'h11, 1'b0, 1'b1};
    rx_tab[3] = '{8'h11, 1'b1, 1'b0};
    rx_tab[4] = '{8'h13, 1'b0, 1'b0};
    rx_tab[5] = '{8'h00, 1'b1, 1'b0};
    rx_tab[6] = '{8'h13, 1'b1, 1'b1};
    rx_tab[7] = '{8'h11, 1'b1, 1'b0};

    // Clock/reset
    rst_n = 1'b0;
    pkt_data = 32'h0; pkt_valid = 1'b0;
    fc_req = 1'b0; fc_byte = 8'h00;
    rx_byte = 8'h00; rx_byte_valid = 1'b0;
    tx_busy_n = 1'b1;
    fork monitor(); join_none
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd1);
    chk("rst_tx_wr_n", 32'(tx_wr_n), 32'd1);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_fc_ack", 32'(fc_ack), 32'd0);
    chk("rst_xoff", 32'(xoff_active), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_state_arb", 32'(dbg_state), 32'd0);

    // Packet table: byte order, spacing, pkt_ready after the last strobe
    for (int i = 0; i < 4; i++) begin
      sc = strobe_cnt;
      send_pkt(pkt_tab[i].data, pkt_tab[i].exp_b, 1'b1);
      wait_strobes(sc + 4, 200);
      step();
      chk("pkt_ready_after_last", 32'(pkt_ready), 32'd1);
      chk("pkt_count_table", 32'(pkt_count), 32'(exp_pkts));
      drain();
    end

    // XON/XOFF decode table
    for (int i = 0; i < 8; i++) begin
      rx_byte       = rx_tab[i].b;
      rx_byte_valid = rx_tab[i].v;
      step();
      rx_byte_valid = 1'b0;
      chk("xoff_decode", 32'(xoff_active), 32'(rx_tab[i].exp_xoff));
    end

    // Busy stall after the second byte
    sc = strobe_cnt;
    send_pkt(32'hDEADBEEF, {8'hDE, 8'hAD, 8'hBE, 8'hEF}, 1'b1);
    wait_strobes(sc + 2, 200);
    tx_busy_n = 1'b0;
    sc = strobe_cnt;
    repeat (100) step();
    chk("busy_no_strobe", 32'(strobe_cnt), 32'(sc));
    tx_busy_n = 1'b1;
    step();
    chk("busy_release_wr", 32'(tx_wr_n), 32'd0);
    chk("busy_release_data", 32'(tx_data), 32'hBE);
    drain();
    chk("busy_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Mid-word XOFF then XON
    sc = strobe_cnt;
    send_pkt(32'h01020304, {8'h01, 8'h02, 8'h03, 8'h04}, 1'b1);
    wait_strobes(sc + 2, 200);
    rx_send(8'h13);
    chk("xoff_set", 32'(xoff_active), 32'd1);
    sc = strobe_cnt;
    repeat (200) step();
    chk("xoff_no_strobe", 32'(strobe_cnt), 32'(sc));
    chk("xoff_count_held", 32'(pkt_count), 32'(exp_pkts - 1));
    rx_send(8'h11);
    chk("xon_clear", 32'(xoff_active), 32'd0);
    drain();
    chk("xon_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Control byte during XOFF, then a control byte inserted mid-word
    rx_send(8'h13);
    bb = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_pkt(32'hA1A2A3A4, bb, 1'b0);
    exp_pkts++;
    send_fc(8'h11);
    sc = strobe_cnt;
    repeat (50) step();
    chk("fc_no_data_follow", 32'(strobe_cnt), 32'(sc));
    chk("fc_xoff_still", 32'(xoff_active), 32'd1);
    push_byte(1'b0, 8'hA1);
    push_byte(1'b0, 8'hA2);
    rx_send(8'h11);
    wait_strobes(sc + 2, 200);
    send_fc(8'h13);
    push_byte(1'b0, 8'hA3);
    push_byte(1'b0, 8'hA4);
    drain();
    chk("fc_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Back-to-back packets with valid held
    sc = strobe_cnt;
    send_pkt(32'h11223344, {8'h11, 8'h22, 8'h33, 8'h44}, 1'b1);
    send_pkt(32'h55667788, {8'h55, 8'h66, 8'h77, 8'h88}, 1'b1);
    drain();
    chk("b2b_strobes", 32'(strobe_cnt - sc), 32'd8);
    chk("b2b_pkt_count", 32'(pkt_count), 32'(exp_pkts));

    // Counter wrap
    force dut.pkt_count = 16'hFFFF;
    step();
    release dut.pkt_count;
    step();
    chk("wrap_preload", 32'(pkt_count), 32'hFFFF);
    send_pkt(32'h0BADF00D, {8'h0B, 8'hAD, 8'hF0, 8'h0D}, 1'b1);
    drain();
    chk("wrap_to_zero", 32'(pkt_count), 32'h0000);
    exp_pkts = 0;

    // Asynchronous reset mid-word
    sc = strobe_cnt;
    send_pkt(32'hCAFEF00D, {8'hCA, 8'hFE, 8'hF0, 8'h0D}, 1'b1);
    wait_strobes(sc + 2, 200);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_wr_n", 32'(tx_wr_n), 32'd1);
    chk("async_rst_pkt_ready", 32'(pkt_ready), 32'd1);
    chk("async_rst_pkt_count", 32'(pkt_count), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    sc = strobe_cnt;
    repeat (50) step();
    chk("post_rst_no_strobe", 32'(strobe_cnt), 32'(sc));
    chk("post_rst_pkt_ready", 32'(pkt_ready), 32'd1);

    // Normal operation resumes after reset
    send_pkt(32'h5A5AA5A5, {8'h5A, 8'h5A, 8'hA5, 8'hA5}, 1'b1);
    drain();
    chk("post_rst_pkt_count", 32'(pkt_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
